// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// An owner keeps the mux until it releases or, when others wait, until MAX_HOLD busy cycles pass; every handover has a one-cycle dead gap.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              preempt_q, preempt_d;

  logic       win_valid;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       others_waiting;

  // Cyclic search from ptr: iterating downwards lets the nearest requester overwrite farther ones.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win_valid = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  assign owner_req      = req[sel_q];
  assign others_waiting = (req & ~grant_q) != 4'b0000;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          cnt_d   = HOLD_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req ||
            (MAX_HOLD != 0 && cnt_q == MAX_HOLD_C && others_waiting)) begin
          // sel is left alone so the mux stays stable through the dead cycle.
          grant_d   = 4'b0000;
          ptr_d     = sel_q + 2'd1;
          cnt_d     = '0;
          state_d   = IDLE;
          preempt_d = owner_req;
        end else if (cnt_q < MAX_HOLD_C) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = (state_q == BUSY);
  assign preempt = preempt_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 gate-level mux datapath between four requesters. It owns the mux select lines s0/s1 and grants the shared output to exactly one requester at a time. It enforces a one-cycle break-before-make gap between owners and an optional hold-time limit. It sits between the requesting agents and the m41 mux instance; sel[0] drives s0 and sel[1] drives s1.

Parameters:
MAX_HOLD, 8, maximum consecutive BUSY cycles per grant before preemption when other requests are pending; 0 disables preemption.
HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
clk  input  1  single system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  4  request vector; req[i] asks for mux input i (0=a, 1=b, 2=c, 3=d).
grant  output  4  one-hot grant, registered; all zero when no owner.
sel  output  2  registered mux select; sel = index of the current or last owner; sel[0]->s0, sel[1]->s1.
busy  output  1  high while a grant is active.
preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, any state): grant=4'b0000, sel=2'b00, busy=0, preempt=0, state=IDLE, priority pointer ptr=0, hold counter cnt=0. Deassertion is sampled on the next clk edge.
- State encoding: two states, IDLE and BUSY.
- IDLE, req==0:
  - Outputs hold: grant=0, busy=0.
  - sel keeps its last value.
- IDLE, req!=0:
  - Pick the winner w: the first i with req[i]=1, searching cyclically ptr, ptr+1, ..., ptr+3 (mod 4).
  - Next edge: grant=1<<w, sel=w, busy=1, cnt=1, state=BUSY.
  - Latency: 1 cycle from a req sampled in IDLE to grant.
- BUSY, req[owner]==0 (release):
  - Next edge: grant=0, busy=0, ptr=owner+1 (mod 4, wraps 3->0), cnt=0, state=IDLE.
  - sel is unchanged.
  - The following IDLE cycle is the mandatory dead cycle. The earliest next grant is 2 edges after the release is sampled.
- BUSY, req[owner]==1, MAX_HOLD!=0, cnt==MAX_HOLD, and (req & ~grant)!=0 (preempt):
  - Next edge: same as release, plus preempt=1 for exactly one cycle.
- BUSY, req[owner]==1, otherwise:
  - Hold the grant.
  - cnt increments and saturates at MAX_HOLD; it never wraps.
  - A lone requester keeps the grant indefinitely.
- Simultaneous events:
  - Owner release and other requests in the same cycle are treated as a release.
  - Requests arriving during BUSY are only considered in IDLE.
  - Changes to req[i] for non-owners during BUSY have no effect.
- Invariants:
  - grant is always one-hot or zero.
  - grant!=0 if and only if busy=1.
  - While busy=1, sel equals the index of the set grant bit.
  - sel changes only on the edge where grant goes from zero to nonzero, so the mux select is stable for the whole grant plus the dead cycle.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,...
- Arithmetic: ptr is 2-bit modulo-4; cnt is HOLD_W bits, unsigned.

Test Plan:
- Reset mid-grant: grant=4'b0100, then drop rst_n asynchronously between edges -> grant=0, sel=0, busy=0 immediately; first grant after release with req=4'b1111 is index 0.
- Single request: req=4'b0010 at edge 0 -> grant=4'b0010, sel=2'b01, busy=1 after edge 1; drop req -> grant=0 after the next edge; sel stays 2'b01.
- Round-robin rotation: req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 in sequence, each 8 cycles long, with preempt pulsing and one idle cycle between grants.
- Wrap and skip: ptr=3 (last owner 2), req=4'b0101 -> winner 0, not 2; then winner 2 next.
- Lone holder: req=4'b1000 held for 40 cycles, MAX_HOLD=8 -> grant stays 4'b1000, no preempt, cnt saturates at 8.
- Preemption disabled: MAX_HOLD=0, req=4'b0011 held for 30 cycles -> grant stays 4'b0001 throughout; preempt never asserts.
